// File: rtl/snake_pkg.sv
// Shared definitions for the snake animator on the two-digit split-segment display.
// Segment bit order is {a1,a2,b1,b2,c1,c2,d1,d2,e1,e2,f1,f2,g1,g2}, bit 13 = a1.
package snake_pkg;

    localparam int SEG_W    = 14;
    localparam int POS_W    = 4;
    localparam int CLEN_W   = 4;   // wide enough for any length up to 11
    localparam int PATH_LEN = 12;

    localparam int SEG_A1 = 13;
    localparam int SEG_A2 = 12;
    localparam int SEG_B1 = 11;
    localparam int SEG_B2 = 10;
    localparam int SEG_C1 = 9;
    localparam int SEG_C2 = 8;
    localparam int SEG_D1 = 7;
    localparam int SEG_D2 = 6;
    localparam int SEG_E1 = 5;
    localparam int SEG_E2 = 4;
    localparam int SEG_F1 = 3;
    localparam int SEG_F2 = 2;
    localparam int SEG_G1 = 1;
    localparam int SEG_G2 = 0;

    typedef logic [3:0] seg_idx_t;

    // Figure-eight path through both digits; g1/g2 are crossed twice.
    localparam seg_idx_t PATH [PATH_LEN] = '{
        seg_idx_t'(SEG_A1), seg_idx_t'(SEG_A2), seg_idx_t'(SEG_B2), seg_idx_t'(SEG_G2),
        seg_idx_t'(SEG_G1), seg_idx_t'(SEG_E1), seg_idx_t'(SEG_D1), seg_idx_t'(SEG_D2),
        seg_idx_t'(SEG_C2), seg_idx_t'(SEG_G2), seg_idx_t'(SEG_G1), seg_idx_t'(SEG_F1)
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // (pos + ofs) mod 12; pos <= 11 and ofs <= 10, so one correction is enough.
    function automatic logic [POS_W-1:0] path_index(input logic [POS_W-1:0] pos,
                                                     input logic [POS_W-1:0] ofs);
        logic [POS_W:0] sum;
        sum = {1'b0, pos} + {1'b0, ofs};
        path_index = (sum >= 5'd12) ? POS_W'(sum - 5'd12) : POS_W'(sum);
    endfunction

    // One-hot segment mask for a path position; out-of-range positions light nothing.
    function automatic logic [SEG_W-1:0] path_mask(input logic [POS_W-1:0] idx);
        case (idx)
            4'd0:    path_mask = 14'd1 << PATH[0];
            4'd1:    path_mask = 14'd1 << PATH[1];
            4'd2:    path_mask = 14'd1 << PATH[2];
            4'd3:    path_mask = 14'd1 << PATH[3];
            4'd4:    path_mask = 14'd1 << PATH[4];
            4'd5:    path_mask = 14'd1 << PATH[5];
            4'd6:    path_mask = 14'd1 << PATH[6];
            4'd7:    path_mask = 14'd1 << PATH[7];
            4'd8:    path_mask = 14'd1 << PATH[8];
            4'd9:    path_mask = 14'd1 << PATH[9];
            4'd10:   path_mask = 14'd1 << PATH[10];
            4'd11:   path_mask = 14'd1 << PATH[11];
            default: path_mask = 14'd0;
        endcase
    endfunction

endpackage

// File: rtl/snake_seg_decode.sv
// Combinational segment decoder: lights cur_len consecutive path entries from pos.
// Overlapping g1/g2 entries simply OR together.
module snake_seg_decode
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 6
) (
    input  logic [POS_W-1:0]  pos,
    input  logic [CLEN_W-1:0] cur_len,
    input  logic              active,
    output logic [SEG_W-1:0]  seg
);

    // OR together the masks of the first cur_len path positions starting at pos.
    always_comb begin
        seg = {SEG_W{1'b0}};
        if (active) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg = seg | ((CLEN_W'(i) < cur_len) ?
                             path_mask(path_index(pos, POS_W'(i))) : {SEG_W{1'b0}});
            end
        end else begin
            seg = {SEG_W{1'b0}};
        end
    end

endmodule

// File: rtl/snake_animator.sv
// Snake animator for the two-digit split-segment display.
// Programmable step rate (DIV), selectable length, run/pause/stop, direction,
// step/lap pulses. Optional macro SNAKE_GROW_EN makes the snake grow by one
// segment per lap up to MAX_LEN, then fall back to the start length.
module snake_animator
    import snake_pkg::*;
#(
    parameter int DIV     = 1,
    parameter int MAX_LEN = 6,
    parameter int DEF_LEN = 3,
    parameter int LEN_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             dir,
    input  logic [LEN_W-1:0] len,
    output logic [SEG_W-1:0] seg,
    output logic             step_tick,
    output logic             lap,
    output logic             busy
);

    localparam int                 PRESC_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(PATH_LEN - 1);
    localparam logic [CLEN_W-1:0]  DEF_CLEN   = CLEN_W'(DEF_LEN);
    localparam logic [CLEN_W-1:0]  MAX_CLEN   = CLEN_W'(MAX_LEN);

    state_t              state_r, state_s;
    logic [POS_W-1:0]    pos_r, pos_s;
    logic [PRESC_W-1:0]  presc_r, presc_s;
    logic [CLEN_W-1:0]   cur_len_r, cur_len_s;
    logic                step_tick_r, step_tick_s;
    logic                lap_r, lap_s;
    logic                advance_s;
    logic                wrap_s;
    logic [POS_W-1:0]    pos_step_s;
    logic [CLEN_W-1:0]   start_len_s;
`ifdef SNAKE_GROW_EN
    logic [CLEN_W-1:0]   base_len_r, base_len_s;
`endif

    // Length chosen at start: zero selects the default, larger values clamp to MAX_LEN.
    always_comb begin
        if (len == {LEN_W{1'b0}}) begin
            start_len_s = DEF_CLEN;
        end else if (32'(len) > 32'(MAX_LEN)) begin
            start_len_s = MAX_CLEN;
        end else begin
            start_len_s = CLEN_W'(len);
        end
    end

    // Next path position in the current direction and whether it wraps the lap.
    always_comb begin
        if (dir) begin
            wrap_s     = (pos_r == {POS_W{1'b0}});
            pos_step_s = wrap_s ? POS_LAST : pos_r - 4'd1;
        end else begin
            wrap_s     = (pos_r == POS_LAST);
            pos_step_s = wrap_s ? {POS_W{1'b0}} : pos_r + 4'd1;
        end
    end

    // Control FSM and datapath next-state; every non-paused active edge advances the prescaler.
    always_comb begin
        state_s     = state_r;
        pos_s       = pos_r;
        presc_s     = presc_r;
        cur_len_s   = cur_len_r;
        step_tick_s = 1'b0;
        lap_s       = 1'b0;
        advance_s   = 1'b0;
`ifdef SNAKE_GROW_EN
        base_len_s  = base_len_r;
`endif

        case (state_r)
            IDLE: begin
                if (stop || pause) begin
                    state_s = IDLE;
                end else if (start) begin
                    state_s   = RUN;
                    pos_s     = {POS_W{1'b0}};
                    presc_s   = {PRESC_W{1'b0}};
                    cur_len_s = start_len_s;
`ifdef SNAKE_GROW_EN
                    base_len_s = start_len_s;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_s = IDLE;
                    pos_s   = {POS_W{1'b0}};
                    presc_s = {PRESC_W{1'b0}};
                end else if (pause) begin
                    state_s = HOLD;
                end else begin
                    advance_s = 1'b1;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_s = IDLE;
                    pos_s   = {POS_W{1'b0}};
                    presc_s = {PRESC_W{1'b0}};
                end else if (pause) begin
                    state_s = HOLD;
                end else begin
                    // The release edge counts as a running cycle so no time is lost.
                    state_s   = RUN;
                    advance_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                pos_s   = {POS_W{1'b0}};
                presc_s = {PRESC_W{1'b0}};
            end
        endcase

        if (advance_s) begin
            if (presc_r == PRESC_LAST) begin
                presc_s     = {PRESC_W{1'b0}};
                pos_s       = pos_step_s;
                step_tick_s = 1'b1;
                lap_s       = wrap_s;
`ifdef SNAKE_GROW_EN
                if (wrap_s) begin
                    cur_len_s = (cur_len_r < MAX_CLEN) ? cur_len_r + 4'd1 : base_len_r;
                end else begin
                    cur_len_s = cur_len_r;
                end
`endif
            end else begin
                presc_s = presc_r + PRESC_W'(1'b1);
            end
        end else begin
            presc_s = presc_s;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            pos_r       <= {POS_W{1'b0}};
            presc_r     <= {PRESC_W{1'b0}};
            cur_len_r   <= DEF_CLEN;
            step_tick_r <= 1'b0;
            lap_r       <= 1'b0;
`ifdef SNAKE_GROW_EN
            base_len_r  <= DEF_CLEN;
`endif
        end else begin
            state_r     <= state_s;
            pos_r       <= pos_s;
            presc_r     <= presc_s;
            cur_len_r   <= cur_len_s;
            step_tick_r <= step_tick_s;
            lap_r       <= lap_s;
`ifdef SNAKE_GROW_EN
            base_len_r  <= base_len_s;
`endif
        end
    end

    assign step_tick = step_tick_r;
    assign lap       = lap_r;
    assign busy      = (state_r != IDLE);

    snake_seg_decode #(
        .MAX_LEN (MAX_LEN)
    ) u_decode (
        .pos     (pos_r),
        .cur_len (cur_len_r),
        .active  (busy),
        .seg     (seg)
    );

endmodule

// File: tb/tb_snake_animator.sv
// Directed bench for snake_animator: one DIV=4 and one DIV=1 instance,
// hand-computed segment patterns, default build (SNAKE_GROW_EN undefined).
module tb_snake_animator;

    logic        clk = 1'b0;
    logic        reset;

    logic        start4, stop4, pause4, dir4;
    logic [3:0]  len4;
    logic [13:0] seg4;
    logic        step4, lap4, busy4;

    logic        start1, stop1, pause1, dir1;
    logic [3:0]  len1;
    logic [13:0] seg1;
    logic        step1, lap1, busy1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    snake_animator #(.DIV(4), .MAX_LEN(6), .DEF_LEN(3), .LEN_W(4)) u_div4 (
        .clk(clk), .reset(reset), .start(start4), .stop(stop4), .pause(pause4),
        .dir(dir4), .len(len4), .seg(seg4), .step_tick(step4), .lap(lap4), .busy(busy4)
    );

    snake_animator #(.DIV(1), .MAX_LEN(6), .DEF_LEN(3), .LEN_W(4)) u_div1 (
        .clk(clk), .reset(reset), .start(start1), .stop(stop1), .pause(pause1),
        .dir(dir1), .len(len1), .seg(seg1), .step_tick(step1), .lap(lap1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int steps;
        int laps;
        logic [13:0] len1_seq [4];
        len1_seq = '{14'h2000, 14'h1000, 14'h0400, 14'h0001};

        reset  = 1'b0;
        start4 = 1'b0; stop4 = 1'b0; pause4 = 1'b0; dir4 = 1'b0; len4 = 4'd0;
        start1 = 1'b0; stop1 = 1'b0; pause1 = 1'b0; dir1 = 1'b0; len1 = 4'd0;

        // Reset state
        #12;
        check("rst_seg4",  16'(seg4),  16'h0000);
        check("rst_busy4", 16'(busy4), 16'h0000);
        check("rst_step4", 16'(step4), 16'h0000);
        check("rst_lap4",  16'(lap4),  16'h0000);
        check("rst_seg1",  16'(seg1),  16'h0000);
        #5 reset = 1'b1;
        tick();
        check("idle_busy4", 16'(busy4), 16'h0000);

        // DIV=4, len=3, forward: four cycles per position
        len4 = 4'd3; dir4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("d4_pos0_seg",  16'(seg4),  16'h3400);
        check("d4_pos0_busy", 16'(busy4), 16'h0001);
        check("d4_pos0_step", 16'(step4), 16'h0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("d4_pos0_hold", 16'(seg4), 16'h3400);
        end
        tick();
        check("d4_pos1_seg",  16'(seg4),  16'h1401);
        check("d4_pos1_step", 16'(step4), 16'h0001);
        check("d4_pos1_lap",  16'(lap4),  16'h0000);
        tick();
        check("d4_step_pulse_end", 16'(step4), 16'h0000);

        // Remaining 11 steps to close the lap
        steps = 0;
        laps  = 0;
        for (int k = 0; k < 43; k++) begin
            tick();
            if (step4) steps++;
            if (lap4) laps++;
        end
        check("d4_lap_steps", 16'(steps), 16'd11);
        check("d4_lap_count", 16'(laps),  16'd1);
        check("d4_lap_pulse", 16'(lap4),  16'h0001);
        check("d4_lap_step",  16'(step4), 16'h0001);
        check("d4_lap_seg",   16'(seg4),  16'h3400);

        // Pause mid-prescale: two counts done, two remain after release
        tick();
        tick();
        pause4 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("d4_pause_seg", 16'(seg4), 16'h3400);
        end
        check("d4_pause_busy", 16'(busy4), 16'h0001);
        pause4 = 1'b0;
        tick();
        check("d4_resume1_seg",  16'(seg4),  16'h3400);
        check("d4_resume1_step", 16'(step4), 16'h0000);
        tick();
        check("d4_resume2_seg",  16'(seg4),  16'h1401);
        check("d4_resume2_step", 16'(step4), 16'h0001);

        // stop beats pause
        stop4 = 1'b1; pause4 = 1'b1;
        tick();
        check("d4_stop_busy", 16'(busy4), 16'h0000);
        check("d4_stop_seg",  16'(seg4),  16'h0000);
        stop4 = 1'b0; pause4 = 1'b0;
        tick();
        check("d4_stay_idle", 16'(busy4), 16'h0000);

        // DIV=1, len=0 -> default 3, reverse from pos 0
        len1 = 4'd0; dir1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("d1_rev_pos0", 16'(seg1), 16'h3400);
        tick();
        check("d1_rev_pos11_seg",  16'(seg1),  16'h3008);
        check("d1_rev_pos11_lap",  16'(lap1),  16'h0001);
        check("d1_rev_pos11_step", 16'(step1), 16'h0001);
        tick();
        check("d1_rev_pos10_seg", 16'(seg1), 16'h200A);
        check("d1_rev_pos10_lap", 16'(lap1), 16'h0000);
        dir1 = 1'b0;
        tick();
        check("d1_fwd_pos11_seg", 16'(seg1), 16'h3008);
        tick();
        check("d1_fwd_pos0_seg", 16'(seg1), 16'h3400);
        check("d1_fwd_pos0_lap", 16'(lap1), 16'h0001);
        stop1 = 1'b1;
        tick();
        stop1 = 1'b0;
        check("d1_stop_busy", 16'(busy1), 16'h0000);
        check("d1_stop_seg",  16'(seg1),  16'h0000);

        // len=1 walks a single segment
        len1 = 4'd1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("d1_len1_seq", 16'(seg1), 16'(len1_seq[k]));
            tick();
        end
        stop1 = 1'b1;
        tick();
        stop1 = 1'b0;

        // len=15 clamps to MAX_LEN=6; start while running is ignored
        len1 = 4'd15; start1 = 1'b1;
        tick();
        check("d1_len15_pos0", 16'(seg1), 16'h3423);
        tick();
        start1 = 1'b0;
        check("d1_len15_pos1", 16'(seg1), 16'h14A3);

        // Asynchronous reset mid-run blanks immediately
        len4 = 4'd0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        #3 reset = 1'b0;
        #1;
        check("arst_seg1",  16'(seg1),  16'h0000);
        check("arst_busy1", 16'(busy1), 16'h0000);
        check("arst_seg4",  16'(seg4),  16'h0000);
        check("arst_busy4", 16'(busy4), 16'h0000);
        #2 reset = 1'b1;
        tick();
        check("arst_idle1", 16'(busy1), 16'h0000);

        // Restart from pos 0 after reset, DIV=1 len=3 forward sequence
        len1 = 4'd3; dir1 = 1'b0; start1 = 1'b1;
        len4 = 4'd0; start4 = 1'b1;
        tick();
        start1 = 1'b0; start4 = 1'b0;
        check("rs_d1_pos0", 16'(seg1), 16'h3400);
        check("rs_d4_pos0", 16'(seg4), 16'h3400);
        tick();
        check("rs_d1_pos1", 16'(seg1), 16'h1401);
        tick();
        check("rs_d1_pos2", 16'(seg1), 16'h0403);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snake_animator.md
Name: snake_animator

Overview:
- Parametrised successor of the fixed 3-segment, 12-step snake on the two-digit split-segment display (a1..g2).
- Adds a programmable step rate, a snake length selectable at start, run/pause/stop control, direction reversal, and step/lap status pulses.
- Sits between the board clock and the 14 segment drive pins. Its outputs feed the display pin mapping directly.

Parameters:
- DIV, default 1: clock cycles per snake step (>=1). DIV=1 steps every clock.
- MAX_LEN, default 6: maximum lit segments (1..11).
- DEF_LEN, default 3: length used when len input is 0 (1..MAX_LEN).
- LEN_W, default 4: width of len input.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: level; starts animation from IDLE.
- stop, input, 1: level; returns to IDLE.
- pause, input, 1: level; freezes animation while high.
- dir, input, 1: 0 = forward along path, 1 = reverse.
- len, input, LEN_W: snake length, sampled on start.
- seg, output, 14: {a1,a2,b1,b2,c1,c2,d1,d2,e1,e2,f1,f2,g1,g2}; bit13=a1 ... bit0=g2; 1 = lit.
- step_tick, output, 1: one-cycle pulse in first cycle of each new position.
- lap, output, 1: one-cycle pulse, coincident with step_tick, when pos wraps.
- busy, output, 1: high when state != IDLE.

Behaviour:
- Path, 12 entries, index 0..11: a1,a2,b2,g2,g1,e1,d1,d2,c2,g2,g1,f1. The g1 and g2 segments each appear twice.
- seg decoding:
  - seg is combinational from registered state.
  - In IDLE, seg = 0.
  - Otherwise seg = OR of PATH[(pos+i) mod 12] for i = 0..cur_len-1.
- Registers: state {IDLE, RUN, HOLD}, pos[3:0] (0..11), presc (0..DIV-1), cur_len, base_len, step_tick, lap.
- Reset (async assert, synchronous release): state=IDLE, pos=0, presc=0, cur_len=base_len=DEF_LEN, step_tick=0, lap=0. This gives seg=0 and busy=0.
- Command priority per edge: stop > pause > start.
- IDLE:
  - start=1 → RUN with pos=0, presc=0.
  - On the same edge, cur_len=base_len = DEF_LEN if len==0, else min(len, MAX_LEN).
- RUN:
  - stop → IDLE.
  - pause → HOLD, with presc and pos frozen.
  - Otherwise, if presc==DIV-1: presc<=0 and pos steps; else presc<=presc+1.
  - start is ignored.
- Step rule:
  - dir=0: pos <= (pos==11) ? 0 : pos+1.
  - dir=1: pos <= (pos==0) ? 11 : pos-1.
  - dir is sampled at the step edge, so a change takes effect on the next step.
- step_tick is registered and is 1 in the cycle after a step edge, i.e. while the new seg is first displayed.
- lap is registered the same way and is 1 when that step wrapped (11→0 forward, 0→11 reverse).
- HOLD:
  - stop → IDLE.
  - pause=0 → RUN; presc resumes from its frozen value, with no extra or lost cycles.
  - seg holds.
- Mid-operation reset: immediate blanking, as per reset values.
- After stop, the next start always restarts at pos=0 and re-samples len.
- Equivalence: with DIV=1, len=3, dir=0, the seg sequence from start repeats with period 12, starting 0x3400, 0x1401, ...

Optional Feature:
- Macro: SNAKE_GROW_EN.
- Defined: at each lap pulse edge, cur_len <= cur_len+1 if cur_len < MAX_LEN, else cur_len <= base_len. The change is visible together with the wrapped pos.
- Not defined: cur_len is constant from start until stop or reset, and no grow logic is synthesised.

Decomposition:
- Package snake_pkg:
  - segment bit-index constants SEG_A1=13 .. SEG_G2=0;
  - PATH_LEN=12;
  - PATH constant array of 12 segment indices;
  - typedef enum state_t {IDLE, RUN, HOLD}.
- Sub-module snake_seg_decode: combinational (pos, cur_len, active) → seg[13:0], using PATH.

Test Plan:
- DIV=4, len=3, dir=0, pulse start:
  - seg=0x3400 for 4 cycles, then 0x1401.
  - step_tick high one cycle at each change.
  - After 12 steps, lap=1 and seg=0x3400 again.
- DIV=1, len=0 (→DEF_LEN=3), dir=1 from pos 0 → next seg=0x3008 (f1,a1,a2) and lap=1 on that step.
- len=1: seg=0x2000, then 0x1000, 0x0400, 0x0001. len=15 with MAX_LEN=6: six segments lit.
- DIV=4, pause for 10 cycles mid-prescale → seg and presc frozen; step occurs exactly the remaining cycles after release. stop+pause together → IDLE, seg=0, busy=0.
- reset deasserted low mid-RUN, asynchronously between edges → seg=0, busy=0 immediately. After release, start resumes from pos 0.
- With SNAKE_GROW_EN, DEF_LEN=3, MAX_LEN=5:
  - lengths per lap are 3,4,5,3.
  - At the first lap boundary, seg=0x3401 (a1,a2,b2,g2).
